// File: rtl/lcd_pkg.sv
// Shared types and default timing for the HD44780 read path.
// States, timing defaults and RS encodings used by lcd_status_reader.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    E_HI  = 3'd2,
    E_LO  = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam int T_AS    = 4;
  localparam int T_PW    = 25;
  localparam int T_REC   = 25;
  localparam int TIMEOUT = 100000;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with a zero flag.
// Shared by the setup, enable-high and recovery phases.
module lcd_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read-cycle engine: status/data reads with optional BF polling.
// Define LCD_BUSY_TIMEOUT_EN to bound polling by TIMEOUT cycles.
module lcd_status_reader #(
  parameter int T_AS    = lcd_pkg::T_AS,
  parameter int T_PW    = lcd_pkg::T_PW,
  parameter int T_REC   = lcd_pkg::T_REC,
  parameter int TIMEOUT = lcd_pkg::TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] db_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_oe_n,
  output logic       busy,
  output logic       done,
  output logic       bf,
  output logic [6:0] ac,
  output logic [7:0] rdata,
  output logic       timeout
);

  import lcd_pkg::*;

  localparam int TW = 16;

  state_t        state;
  logic          rs_q;
  logic          poll_q;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_zero;
  logic          repoll;
  logic          again;

  lcd_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .value(t_val),
    .zero (t_zero)
  );

  // bf here is the value sampled on the E pulse that just ended
  assign repoll = poll_q && (rs_q == RS_CMD) && bf;

`ifdef LCD_BUSY_TIMEOUT_EN
  logic [31:0] poll_cnt;
  logic        expired;
  logic        to_q;

  assign expired = (poll_cnt + 32'd1) >= 32'(TIMEOUT);
  assign again   = repoll && !expired;
  assign timeout = to_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
      to_q     <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        poll_cnt <= '0;
        to_q     <= 1'b0;
      end
    end else begin
      poll_cnt <= poll_cnt + 32'd1;
      if (state == E_LO && t_zero && repoll && expired) begin
        to_q <= 1'b1;
      end
    end
  end
`else
  assign again   = repoll;
  assign timeout = 1'b0;
`endif

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          t_load = 1'b1;
          t_val  = TW'(T_AS - 1);
        end
      end
      SETUP: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = TW'(T_PW - 1);
        end
      end
      E_HI: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = TW'(T_REC - 1);
        end
      end
      CHECK: begin
        if (!done) begin
          t_load = 1'b1;
          t_val  = TW'(T_AS - 1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_oe_n <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf       <= 1'b0;
      ac       <= '0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            rs_q     <= rs_sel;
            poll_q   <= poll;
            lcd_rs   <= rs_sel;
            lcd_rw   <= 1'b1;
            lcd_oe_n <= 1'b1;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (t_zero) begin
            lcd_e <= 1'b1;
            state <= E_HI;
          end
        end
        E_HI: begin
          if (t_zero) begin
            lcd_e <= 1'b0;
            state <= E_LO;
            if (rs_q == RS_CMD) begin
              {bf, ac} <= db_in;
            end else begin
              rdata <= db_in;
            end
          end
        end
        E_LO: begin
          if (t_zero) begin
            state <= CHECK;
            // rw and oe_n drop together, so the bus is never double-driven
            if (!again) begin
              done     <= 1'b1;
              lcd_rw   <= 1'b0;
              lcd_oe_n <= 1'b0;
              lcd_rs   <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= SETUP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Self-checking bench for lcd_status_reader (default build).
// Cycle-position model plus directed literal checks and random traffic.
module tb_lcd_status_reader;

  localparam int T_AS  = 4;
  localparam int T_PW  = 25;
  localparam int T_REC = 25;
  localparam int L     = T_AS + T_PW + T_REC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic [7:0] db_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_oe_n;
  logic       busy, done, bf, timeout;
  logic [6:0] ac;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  lcd_status_reader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rs_sel  (rs_sel),
    .poll    (poll),
    .db_in   (db_in),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_e   (lcd_e),
    .lcd_oe_n(lcd_oe_n),
    .busy    (busy),
    .done    (done),
    .bf      (bf),
    .ac      (ac),
    .rdata   (rdata),
    .timeout (timeout)
  );

  // Model: position within a transaction, n = 1 on the first cycle after start
  bit         m_act, m_rs, m_poll, m_last;
  int         m_n;
  logic       m_bf;
  logic [6:0] m_ac;
  logic [7:0] m_rdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_n = 0; m_rs = 0; m_poll = 0; m_last = 0;
      m_bf = 0; m_ac = '0; m_rdata = '0;
    end else if (m_act) begin
      if (m_n % L == 0 && m_last) begin
        m_act = 0;
        m_n = 0;
      end else begin
        m_n++;
        if ((m_n - 1) % L == T_AS + T_PW) begin
          if (m_rs) m_rdata = db_in;
          else {m_bf, m_ac} = db_in;
          m_last = !(m_poll && !m_rs && db_in[7]);
        end
      end
    end else if (start) begin
      m_act = 1; m_n = 1; m_rs = rs_sel; m_poll = poll; m_last = 0;
    end
  end

  function automatic logic [22:0] dvec();
    return {lcd_rs, lcd_rw, lcd_e, lcd_oe_n, busy, done,
            bf, ac, rdata, timeout};
  endfunction

  always @(negedge clk) begin
    int p;
    logic e_x, fin, rw_x;
    logic [22:0] ex;
    if (cmp_en) begin
      p    = m_act ? (m_n - 1) % L : 0;
      e_x  = m_act && p >= T_AS && p < T_AS + T_PW;
      fin  = m_act && p == L - 1 && m_last;
      rw_x = m_act && !fin;
      ex   = {rw_x & m_rs, rw_x, e_x, rw_x, m_act, fin,
              m_bf, m_ac, m_rdata, 1'b0};
      checks++;
      if (dvec() !== ex) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dvec(), ex);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_read(input bit rs, input bit pl,
                         input logic [7:0] da, input logic [7:0] dbv,
                         input int flip, input int ign,
                         output int lat, output int ehi, output int np,
                         output int nd, output int bad);
    int cyc;
    int nfall;
    bit pe;
    lat = 0; ehi = 0; np = 0; nd = 0; bad = 0; nfall = 0; pe = 0;
    db_in = da; rs_sel = rs; poll = pl; start = 1;
    cyc = 1;
    while (cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == ign);
      if (lcd_e) ehi++;
      if (lcd_e && !pe) np++;
      if (!lcd_e && pe) begin
        nfall++;
        if (nfall == flip) db_in = dbv;
      end
      pe = lcd_e;
      if (done) begin
        nd++;
        if (lat == 0) lat = cyc;
      end else if (lat == 0 &&
                   (lcd_rw !== 1'b1 || lcd_oe_n !== 1'b1 || lcd_rs !== rs)) begin
        bad++;
      end
      if (lat != 0 && cyc == lat + 3) break;
    end
    start = 0;
  endtask

  initial begin
    int lat, ehi, np, nd, bad;
    rst = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    cmp_en = 1;
    @(posedge clk); #1;
    chk("reset_outputs", 32'(dvec()), 32'h0);

    // single status read
    do_read(0, 0, 8'h45, 8'h45, 0, 0, lat, ehi, np, nd, bad);
    chk("stat_latency", lat, 56);
    chk("stat_e_cycles", ehi, 25);
    chk("stat_e_pulses", np, 1);
    chk("stat_done_cnt", nd, 1);
    chk("stat_rw_oe_held", bad, 0);
    chk("stat_bf", 32'(bf), 0);
    chk("stat_ac", 32'(ac), 32'h45);
    chk("stat_oe_after", 32'(lcd_oe_n), 0);

    // data read; status registers must not move
    do_read(1, 0, 8'hA5, 8'hA5, 0, 0, lat, ehi, np, nd, bad);
    chk("data_latency", lat, 56);
    chk("data_rs_held", bad, 0);
    chk("data_rdata", 32'(rdata), 32'hA5);
    chk("data_ac_kept", 32'(ac), 32'h45);
    chk("data_bf_kept", 32'(bf), 0);

    // busy poll: three BF=1 samples, then BF=0
    do_read(0, 1, 8'h80, 8'h12, 3, 0, lat, ehi, np, nd, bad);
    chk("poll_e_pulses", np, 4);
    chk("poll_done_cnt", nd, 1);
    chk("poll_latency", lat, 56 + 3 * L);
    chk("poll_bf", 32'(bf), 0);
    chk("poll_ac", 32'(ac), 32'h12);

    // start while busy is ignored
    do_read(0, 0, 8'h3C, 8'h3C, 0, 10, lat, ehi, np, nd, bad);
    chk("ign_e_pulses", np, 1);
    chk("ign_done_cnt", nd, 1);
    chk("ign_latency", lat, 56);
    chk("ign_busy_after", 32'(busy), 0);

    // reset during E high
    db_in = 8'hFF; rs_sel = 0; poll = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_e_high", 32'(lcd_e), 1);
    rst = 0;
    #1;
    chk("mid_reset_outputs", 32'(dvec()), 32'h0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(dvec()), 32'h0);
    do_read(0, 0, 8'h07, 8'h07, 0, 0, lat, ehi, np, nd, bad);
    chk("post_reset_latency", lat, 56);
    chk("post_reset_ac", 32'(ac), 32'h07);

    // random traffic checked cycle by cycle against the model
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      rst    = ($urandom_range(0, 1999) != 0);
      start  = ($urandom_range(0, 7) == 0);
      rs_sel = 1'($urandom);
      poll   = 1'($urandom);
      db_in  = 8'($urandom);
    end
    @(posedge clk); #1;
    rst = 1; start = 0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the HD44780 write FSM. Performs RW=1 bus cycles on the LCD.
- Two read types: a status read (RS=0, returns busy flag and address counter) and a DDRAM/CGRAM data read (RS=1).
- Optional busy-poll mode repeats status reads until BF=0, so the write path can sequence on BF instead of fixed delays.
- Sits between the top-level mux/fsm arbitration and the LCD pins; clocked from the 50 MHz system clock.

Parameters:
- T_AS, 4, cycles from RS/RW setup to E rising (tAS ≥ 40 ns).
- T_PW, 25, cycles E held high; data sampled on the last high cycle (tPW ≥ 450 ns, tDDR ≤ 360 ns).
- T_REC, 25, cycles E low after falling edge before the next E or release (tH plus cycle time ≥ 1000 ns total).
- TIMEOUT, 100000, maximum poll cycles (2 ms); used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request; ignored unless idle
- rs_sel  in  1  0 = status read, 1 = data read; captured on start
- poll  in  1  1 = repeat status reads until BF=0; captured on start; ignored when rs_sel=1
- db_in  in  8  LCD data bus input
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write (1 = read)
- lcd_e  out  1  LCD enable
- lcd_oe_n  out  1  1 = write-side bus driver tri-stated
- busy  out  1  block active
- done  out  1  one-cycle completion pulse
- bf  out  1  last sampled DB7 (status reads only)
- ac  out  7  last sampled DB6..0 (status reads only)
- rdata  out  8  last sampled byte (data reads only)
- timeout  out  1  poll aborted (optional feature only)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, all outputs 0, counters 0.
- IDLE: lcd_rw=0, lcd_e=0, lcd_oe_n=0.
  - On start: latch rs_sel and poll; lcd_oe_n=1 and lcd_rw=1 and lcd_rs=rs_sel next cycle; busy=1; go to SETUP.
- SETUP: hold for T_AS cycles, then E_HI.
- E_HI: lcd_e=1 for T_PW cycles. On the final cycle, register db_in:
  - rs_sel=0: bf=db_in[7], ac=db_in[6:0].
  - rs_sel=1: rdata=db_in.
- E_LO: lcd_e=0 for T_REC cycles, then CHECK.
- CHECK:
  - If poll, rs_sel=0 and bf=1: go to SETUP with rw/rs unchanged and oe_n still 1.
  - Otherwise: lcd_rw=0, lcd_oe_n=0, lcd_rs=0, done=1 for one cycle; go to IDLE with busy=0.
- Latency of a single read: 1 + T_AS + T_PW + T_REC + 1 cycles from start to done (56 cycles with defaults).
- start while busy: ignored, no queuing.
- Simultaneous start and done: start is ignored (busy is still 1 in that cycle).
- lcd_oe_n rises on or before the cycle lcd_rw rises, and falls no earlier than the cycle lcd_rw falls. This prevents bus contention.
- bf/ac/rdata hold their values until overwritten by the next sample of the same type.
- Reset mid-cycle: E drops immediately; the bus is returned to the write side (oe_n=0, rw=0).

Optional Feature:
- LCD_BUSY_TIMEOUT_EN defined:
  - A poll-cycle counter starts at the first SETUP and clears on start.
  - Reaching TIMEOUT in CHECK with bf=1 ends the transaction: done=1 and timeout=1 in the same cycle.
  - timeout holds until the next start.
- Not defined: the timeout port is tied to 0, there is no counter, and polling is unbounded.

Decomposition:
- Shared package lcd_pkg:
  - State enum (IDLE, SETUP, E_HI, E_LO, CHECK).
  - Default timing constants T_AS/T_PW/T_REC/TIMEOUT.
  - RS encodings RS_CMD=0, RS_DATA=1.
- One natural sub-module, lcd_phase_timer: a loadable down-counter with a zero flag, reused for all three timed phases. The poll timeout counter stays inline.

Test Plan:
- Single status read: start, rs_sel=0, poll=0, db_in=8'h45 → lcd_rw=1 for the whole transaction, lcd_e high for exactly 25 cycles, done at cycle 56, bf=0, ac=7'h45, lcd_oe_n=0 after done.
- Data read: rs_sel=1, db_in=8'hA5 → lcd_rs=1 throughout, rdata=8'hA5, bf/ac unchanged from the previous read.
- Busy poll: poll=1, db_in=8'h80 for three E pulses then 8'h12 → four E pulses, one done, bf=0, ac=7'h12.
- Ignored start: pulse start again at cycle 10 of a read → no extra E pulse, exactly one done.
- Mid-transaction reset: assert rst low during E_HI → lcd_e=0 asynchronously, all outputs 0, IDLE after release.
- With LCD_BUSY_TIMEOUT_EN and TIMEOUT=200: db_in held at 8'h80 → done and timeout asserted together after the first CHECK at or beyond 200 cycles; timeout cleared on the next start.
